// File: rtl/saturn_bus_program_sequencer.sv
// Drains the control unit's bus program ring onto the Saturn nibble bus,
// tracking the 20-bit bus address and returning read nibbles.
module saturn_bus_program_sequencer #(
    parameter int PROG_DEPTH_LOG2 = 5,
    parameter int ADDR_NIBBLES    = 5
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_clk_en,
    input  logic [3:0]                   i_phases,
    input  logic [4:0]                   i_program_data,
    input  logic [PROG_DEPTH_LOG2-1:0]   i_program_address,
    output logic [PROG_DEPTH_LOG2-1:0]   o_program_address,
    output logic [3:0]                   o_bus_data,
    output logic                         o_bus_cmd,
    output logic                         o_bus_strobe,
    input  logic [3:0]                   i_bus_nibble,
    output logic [3:0]                   o_nibble,
    output logic                         o_nibble_valid,
    output logic                         o_bus_busy,
    output logic [4*ADDR_NIBBLES-1:0]    o_address,
    output logic                         o_error
);

    localparam int PW = PROG_DEPTH_LOG2;
    localparam int AW = 4 * ADDR_NIBBLES;
    localparam int CW = $clog2(ADDR_NIBBLES + 1);

    localparam logic [3:0] BUSCMD_PC_READ = 4'h0;
    localparam logic [3:0] BUSCMD_DP_READ = 4'h1;
    localparam logic [3:0] BUSCMD_LOAD_PC = 4'h4;
    localparam logic [3:0] BUSCMD_LOAD_DP = 4'h5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ctr_q, ctr_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      data_q, data_d;
    logic            cmd_q, cmd_d;
    logic            strobe_q, strobe_d;
    logic [3:0]      nib_q, nib_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            seen_q, seen_d;
    logic            skip_q, skip_d;

    logic            pending;
    logic            consume;
    logic            do_read;
    logic            is_cmd;
    logic [3:0]      nib;
    logic            is_load;
    logic            is_read;
    logic            is_other;
    logic            addr_data;
    logic            write_data;
    logic            addr_last;

    assign pending    = (ptr_q != i_program_address);
    assign is_cmd     = i_program_data[4];
    assign nib        = i_program_data[3:0];
    assign is_load    = is_cmd & ((nib == BUSCMD_LOAD_PC) | (nib == BUSCMD_LOAD_DP));
    assign is_read    = is_cmd & ((nib == BUSCMD_PC_READ) | (nib == BUSCMD_DP_READ));
    assign is_other   = is_cmd & ~is_load & ~is_read;
    assign addr_data  = ~is_cmd & (state_q == S_ADDR);
    assign write_data = ~is_cmd & (state_q != S_ADDR);
    assign addr_last  = (ctr_q == CW'(ADDR_NIBBLES - 1));
    assign consume    = i_phases[1] & pending;
    // skip_q blocks the read slot of a bus cycle already used by an entry
    assign do_read    = i_phases[2] & ~pending & ~skip_q & (state_q == S_RUN);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            ctr_q    <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            cmd_q    <= 1'b0;
            strobe_q <= 1'b0;
            nib_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            seen_q   <= 1'b0;
            skip_q   <= 1'b0;
        end else if (i_clk_en) begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cmd_q    <= cmd_d;
            strobe_q <= strobe_d;
            nib_q    <= nib_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            seen_q   <= seen_d;
            skip_q   <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        if (consume) begin
            unique case (1'b1)
                is_load: begin
                    state_d = S_ADDR;
                    ctr_d   = '0;
                end
                is_read:  state_d = S_RUN;
                is_other: state_d = S_IDLE;
                addr_data: begin
                    ctr_d = ctr_q + CW'(1);
                    if (addr_last) state_d = S_RUN;
                end
                write_data: state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cmd_d    = cmd_q;
        strobe_d = 1'b0;
        nib_d    = nib_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        seen_d   = seen_q;
        skip_d   = i_phases[0] ? 1'b0 : skip_q;
        if (consume) begin
            ptr_d    = ptr_q + PW'(1);
            data_d   = nib;
            cmd_d    = is_cmd;
            strobe_d = 1'b1;
            skip_d   = 1'b1;
            if (is_cmd) begin
                seen_d = 1'b1;
                if (state_q == S_ADDR && ctr_q < CW'(ADDR_NIBBLES - 1))
                    err_d = 1'b1;
            end else if (state_q == S_ADDR) begin
                for (int i = 0; i < ADDR_NIBBLES; i++)
                    if (ctr_q == CW'(i)) addr_d[i*4 +: 4] = nib;
            end else begin
                addr_d = addr_q + AW'(1);
                if (!seen_q) err_d = 1'b1;
            end
        end else if (do_read) begin
            nib_d    = i_bus_nibble;
            valid_d  = 1'b1;
            strobe_d = 1'b1;
            cmd_d    = 1'b0;
            addr_d   = addr_q + AW'(1);
        end
    end

    assign o_program_address = ptr_q;
    assign o_bus_data        = data_q;
    assign o_bus_cmd         = cmd_q;
    assign o_bus_strobe      = strobe_q;
    assign o_nibble          = nib_q;
    assign o_nibble_valid    = valid_q;
    assign o_bus_busy        = pending | (state_q == S_ADDR);
    assign o_address         = addr_q;
    assign o_error           = err_q;

endmodule
